// File: rtl/scurve_stream_parser.sv
// Receive-side decoder for the S-curve test data stream: reassembles one record per DAC step
// and checks tag formats and channel/DAC sequencing.
module scurve_stream_parser #(
  parameter int unsigned DATA_WORDS = 2
) (
  input  logic                       Clk,
  input  logic                       reset,
  input  logic                       Parse_Enable,
  input  logic                       Clear_Status,
  input  logic                       fifo_empty,
  input  logic [15:0]                fifo_dout,
  output logic                       fifo_rd_en,
  output logic                       Record_Valid,
  output logic                       Record_Mode,
  output logic [5:0]                 Record_Chn,
  output logic [9:0]                 Record_DAC,
  output logic [16*DATA_WORDS-1:0]   Record_Data,
  output logic                       Parse_Done,
  output logic                       Seq_Error,
  output logic                       Tag_Error,
  output logic [7:0]                 Error_Count,
  output logic [15:0]                Discard_Count,
  output logic [16:0]                Record_Count
);

  localparam int unsigned DBits = 16 * DATA_WORDS;
  localparam int unsigned IdxW  = (DATA_WORDS > 1) ? $clog2(DATA_WORDS) : 1;

  typedef enum logic [2:0] {StIdle, StHunt, StExpChn, StExpDac, StExpData, StEmit} state_e;

  state_e            r_state, w_state_d;
  logic              r_rd_en, r_pend, r_first;
  logic              r_mode;
  logic [5:0]        r_chn, r_exp_chn;
  logic [9:0]        r_dac, r_exp_dac;
  logic [IdxW-1:0]   r_idx;
  logic [DBits-1:0]  r_data;
  logic              r_rec_mode;
  logic [5:0]        r_rec_chn;
  logic [9:0]        r_rec_dac;
  logic [DBits-1:0]  r_rec_data;
  logic              r_seq, r_tag;
  logic [7:0]        r_err_cnt;
  logic [15:0]       r_disc_cnt;
  logic [16:0]       r_rec_cnt;

  logic              w_decode, w_is_hdr, w_chn_ok, w_dac_ok, w_mode_in;
  logic [5:0]        w_chn_in;
  logic [9:0]        w_dac_in;
  logic              w_last, w_done, w_fetch_d;
  logic              w_tag_err, w_discard, w_seq_set, w_ld_chn, w_ld_dac, w_ld_data, w_hdr_sync;
  logic [DBits-1:0]  w_data_shift;

  assign w_decode     = r_pend & Parse_Enable;
  assign w_is_hdr     = (fifo_dout == 16'h5343);
  assign w_chn_ok     = ((fifo_dout[15:8] == 8'h63) || (fifo_dout[15:8] == 8'h43)) &&
                        (fifo_dout[7:6] == 2'b00);
  assign w_dac_ok     = (fifo_dout[15:12] == 4'hD) && (fifo_dout[11:10] == 2'b00);
  assign w_mode_in    = (fifo_dout[15:8] == 8'h63);
  assign w_chn_in     = fifo_dout[5:0];
  assign w_dac_in     = fifo_dout[9:0];
  assign w_data_shift = DBits'({r_data, fifo_dout});
  assign w_last       = (r_dac == 10'h3FF);
  assign w_done       = (r_state == StEmit) && w_last && (r_mode || (r_chn == 6'd63));
  assign w_fetch_d    = (w_state_d == StHunt) || (w_state_d == StExpChn) ||
                        (w_state_d == StExpDac) || (w_state_d == StExpData);

  always_comb begin
    w_state_d  = r_state;
    w_tag_err  = 1'b0;
    w_discard  = 1'b0;
    w_seq_set  = 1'b0;
    w_ld_chn   = 1'b0;
    w_ld_dac   = 1'b0;
    w_ld_data  = 1'b0;
    w_hdr_sync = 1'b0;
    if (!Parse_Enable) begin
      w_state_d = StIdle;
    end else begin
      unique case (r_state)
        StIdle: w_state_d = StHunt;
        StHunt: begin
          if (w_decode) begin
            if (w_is_hdr) begin
              w_state_d  = StExpChn;
              w_hdr_sync = 1'b1;
            end else begin
              w_discard = 1'b1;
            end
          end
        end
        StExpChn: begin
          if (w_decode) begin
            if (w_chn_ok) begin
              w_ld_chn  = 1'b1;
              w_state_d = StExpDac;
              // A run's first channel only has to be 0 in CTest mode.
              if (r_first) w_seq_set = !w_mode_in && (w_chn_in != 6'd0);
              else         w_seq_set = (w_mode_in != r_mode) ||
                                       (!w_mode_in && (w_chn_in != r_exp_chn));
            end else begin
              w_tag_err = 1'b1;
              w_hdr_sync = w_is_hdr;
              w_state_d = w_is_hdr ? StExpChn : StHunt;
            end
          end
        end
        StExpDac: begin
          if (w_decode) begin
            if (w_dac_ok) begin
              w_ld_dac  = 1'b1;
              w_state_d = StExpData;
              w_seq_set = (w_dac_in != r_exp_dac);
            end else begin
              w_tag_err = 1'b1;
              w_hdr_sync = w_is_hdr;
              w_state_d = w_is_hdr ? StExpChn : StHunt;
            end
          end
        end
        StExpData: begin
          if (w_decode) begin
            w_ld_data = 1'b1;
            if (r_idx == IdxW'(DATA_WORDS - 1)) w_state_d = StEmit;
          end
        end
        StEmit: begin
          if (!w_last)                          w_state_d = StExpDac;
          else if (!r_mode && r_chn != 6'd63)   w_state_d = StExpChn;
          else                                  w_state_d = StHunt;
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      r_state    <= StIdle;
      r_rd_en    <= 1'b0;
      r_pend     <= 1'b0;
      r_first    <= 1'b0;
      r_mode     <= 1'b0;
      r_chn      <= '0;
      r_exp_chn  <= '0;
      r_dac      <= '0;
      r_exp_dac  <= '0;
      r_idx      <= '0;
      r_data     <= '0;
      r_rec_mode <= 1'b0;
      r_rec_chn  <= '0;
      r_rec_dac  <= '0;
      r_rec_data <= '0;
      r_seq      <= 1'b0;
      r_tag      <= 1'b0;
      r_err_cnt  <= '0;
      r_disc_cnt <= '0;
      r_rec_cnt  <= '0;
    end else begin
      r_state <= w_state_d;
      // Strobe issue is decided against the next state so decode and the next read overlap.
      r_rd_en <= !r_rd_en && Parse_Enable && !fifo_empty && w_fetch_d;
      r_pend  <= r_rd_en && Parse_Enable;

      if (w_hdr_sync) r_first <= 1'b1;
      if (w_ld_chn) begin
        r_first   <= 1'b0;
        r_mode    <= w_mode_in;
        r_chn     <= w_chn_in;
        r_exp_dac <= '0;
      end
      if (w_ld_dac) begin
        r_dac <= w_dac_in;
        r_idx <= '0;
      end
      if (w_ld_data) begin
        r_data <= w_data_shift;
        r_idx  <= r_idx + 1'b1;
      end
      if (r_state == StExpData && w_state_d == StEmit) begin
        r_rec_mode <= r_mode;
        r_rec_chn  <= r_chn;
        r_rec_dac  <= r_dac;
        r_rec_data <= w_data_shift;
      end
      if (r_state == StEmit) begin
        r_exp_dac <= r_dac + 10'd1;
        r_exp_chn <= r_chn + 6'd1;
      end

      if (Clear_Status) begin
        r_seq      <= 1'b0;
        r_tag      <= 1'b0;
        r_err_cnt  <= '0;
        r_disc_cnt <= '0;
        r_rec_cnt  <= '0;
      end else begin
        if (w_seq_set) r_seq <= 1'b1;
        if (w_tag_err) begin
          r_tag <= 1'b1;
          if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
        end
        if (w_discard && r_disc_cnt != 16'hFFFF) r_disc_cnt <= r_disc_cnt + 16'd1;
        if (r_state == StEmit) r_rec_cnt <= r_rec_cnt + 17'd1;
      end
    end
  end

  assign fifo_rd_en    = r_rd_en;
  assign Record_Valid  = (r_state == StEmit);
  assign Parse_Done    = w_done;
  assign Record_Mode   = r_rec_mode;
  assign Record_Chn    = r_rec_chn;
  assign Record_DAC    = r_rec_dac;
  assign Record_Data   = r_rec_data;
  assign Seq_Error     = r_seq;
  assign Tag_Error     = r_tag;
  assign Error_Count   = r_err_cnt;
  assign Discard_Count = r_disc_cnt;
  assign Record_Count  = r_rec_cnt;

endmodule

// File: doc/scurve_stream_parser.md
# scurve_stream_parser

Receive-side decoder for the S-curve test data stream. Reads the 16-bit word stream that the S-curve test controller writes into the USB data FIFO: header, channel tag, DAC tag, then trigger data words per DAC step. Reassembles one record per DAC step and checks tag formats and channel/DAC sequencing. Used on the readback path and as the self-checking sink in the S-curve benches.

## Interface
- DATA_WORDS, 2: number of trigger data words following each DAC tag; must be ≥1.
- Clk  in  1  sole clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- Parse_Enable  in  1  high: parse; low: return to IDLE.
- Clear_Status  in  1  one-cycle pulse; clears error flags and all counters.
- fifo_empty  in  1  source FIFO empty.
- fifo_dout  in  16  source FIFO data; standard read, valid the cycle after rd_en.
- fifo_rd_en  out  1  registered read strobe; one cycle per word.
- Record_Valid  out  1  one-cycle pulse; record outputs valid.
- Record_Mode  out  1  1 = single-channel (tag 0x63), 0 = CTest 64-channel (tag 0x43).
- Record_Chn  out  6  channel from channel tag.
- Record_DAC  out  10  DAC code from DAC tag.
- Record_Data  out  16*DATA_WORDS  data words; first received in MSBs.
- Parse_Done  out  1  one-cycle pulse with the final record of a run.
- Seq_Error  out  1  sticky; channel or DAC out of sequence.
- Tag_Error  out  1  sticky; malformed word where a tag was expected.
- Error_Count  out  8  tag-error count, saturates at 255.
- Discard_Count  out  16  words discarded while hunting header, saturates at 65535.
- Record_Count  out  17  records emitted, wraps modulo 2^17.
- All outputs reset to 0.

## Operation
- Word formats:
  - header = 0x5343.
  - channel tag = {0x63 or 0x43, 2'b00, chn[5:0]}.
  - DAC tag = {4'hD, 2'b00, dac[9:0]}.
  - Data words are opaque.
- Read phase:
  - In any fetch point with Parse_Enable high and fifo_empty low, assert fifo_rd_en for one cycle.
  - Sample fifo_dout next cycle and decode in that same cycle.
  - Empty FIFO: wait; no strobe.
- States:
  - IDLE → HUNT when Parse_Enable is high.
  - HUNT: header → EXP_CHN; any other word discarded, Discard_Count++.
  - EXP_CHN: valid channel tag → latch mode/chn, expected DAC = 0, → EXP_DAC.
  - EXP_DAC: valid DAC tag → latch code, data index = 0, → EXP_DATA.
  - EXP_DATA: store word; after DATA_WORDS words → EMIT.
  - EMIT: pulse Record_Valid, Record_Count++. Next state:
    - DAC < 1023 → EXP_DAC, expected DAC = code+1.
    - DAC = 1023, CTest mode, chn < 63 → EXP_CHN, expected chn = chn+1.
    - Otherwise pulse Parse_Done → HUNT.
- Tag errors:
  - EXP_CHN/EXP_DAC word fails format (wrong high byte/nibble, nonzero pad bits) → set Tag_Error, Error_Count++, → HUNT.
  - The partial record is dropped.
  - A header word in EXP_CHN/EXP_DAC is a tag error followed by immediate resync: → EXP_CHN, no discard counted.
- Sequence errors:
  - Set Seq_Error when a DAC code differs from expected, a CTest chn differs from expected, or the mode changes within a run.
  - The record is still emitted; expectations resync to the received values.
  - First channel of a CTest run must be 0.
  - Single-mode runs end after DAC 1023.
- Parse_Enable low:
  - Next edge → IDLE.
  - An in-flight word (rd_en already issued) is discarded.
  - Partial record is dropped; status and counters are held.
- Clear_Status takes priority over same-cycle increments.
- reset clears everything, including status.

## Timing
- fifo_rd_en at cycle k → decode at k+1. Peak throughput is one word per 2 cycles.
- Record_Valid is asserted the cycle after the last data word is decoded.
- Record outputs hold until the next Record_Valid.
- Parse_Done is coincident with Record_Valid.
- Tag_Error and the Error_Count increment are visible the cycle after the offending word is decoded.
- No fifo_rd_en in IDLE, in EMIT, or while fifo_empty is high.

## Test plan
- Single-channel run, chn 5, DATA_WORDS=2:
  - Stimulus: 0x5343, 0x6305, then DAC 0x D000..0xD3FF each followed by 2 data words; random empty gaps.
  - Required: 1024 records, Mode=1, Chn=5; DAC 1023 record has Parse_Done; Record_Count=1024; no errors.
- Full CTest run:
  - Stimulus: channels 0x4300..0x433F × 1024 DAC steps.
  - Required: 65536 records, single Parse_Done at chn 63/DAC 1023, Record_Count=65536.
- Garbage before header:
  - Stimulus: 0x1234, 0xD000, then valid single run.
  - Required: Discard_Count=2; run parsed normally.
- DAC skip:
  - Stimulus: 0xD005 then 0xD007.
  - Required: record with DAC=7 emitted, Seq_Error=1; following 0xD008 accepted with no new error.
- Bad tag:
  - Stimulus: 0x7000 where a DAC tag is expected.
  - Required: Tag_Error=1, Error_Count=1; words until the next 0x5343 add to Discard_Count; Clear_Status zeroes all status.
- Parse_Enable dropped mid-record, then new header run:
  - Required: no partial Record_Valid; fresh run parsed correctly; counters retained.
